// File: rtl/countdown_pkg.sv
// Shared encodings, digit limits and BCD helpers for the countdown_multi timer family.
// Optional feature macro used by the design: COUNTDOWN_AUTO_RELOAD_EN.
package countdown_pkg;

    localparam int TIME_W   = 24;
    localparam int N_DIGITS = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] CUR_H1 = 3'd0;
    localparam logic [2:0] CUR_H0 = 3'd1;
    localparam logic [2:0] CUR_M1 = 3'd2;
    localparam logic [2:0] CUR_M0 = 3'd3;
    localparam logic [2:0] CUR_S1 = 3'd4;
    localparam logic [2:0] CUR_S0 = 3'd5;

    localparam logic [3:0] LIM_H1 = 4'd9;
    localparam logic [3:0] LIM_H0 = 4'd9;
    localparam logic [3:0] LIM_M1 = 4'd5;
    localparam logic [3:0] LIM_M0 = 4'd9;
    localparam logic [3:0] LIM_S1 = 4'd5;
    localparam logic [3:0] LIM_S0 = 4'd9;

    localparam logic [TIME_W-1:0] ONE_SEC = 24'h000001;

    function automatic logic [3:0] digit_limit(input logic [2:0] cur);
        case (cur)
            CUR_H1:  return LIM_H1;
            CUR_H0:  return LIM_H0;
            CUR_M1:  return LIM_M1;
            CUR_M0:  return LIM_M0;
            CUR_S1:  return LIM_S1;
            default: return LIM_S0;
        endcase
    endfunction

    // Ripple a one-second borrow from S0 upward; a digit at 0 wraps to its limit and keeps borrowing.
    function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] r;
        logic              borrow;
        logic [3:0]        d;
        r      = t;
        borrow = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            d = t[(N_DIGITS-1-k)*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[(N_DIGITS-1-k)*4 +: 4] = digit_limit(3'(k));
                end else begin
                    r[(N_DIGITS-1-k)*4 +: 4] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_channel.sv
// One HH:MM:SS BCD countdown: FSM, digit editor, decrement and preset register.
// COUNTDOWN_AUTO_RELOAD_EN makes expiry reload the preset and keep running instead of entering DONE.
module countdown_channel
    import countdown_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sel,
    input  logic              i_tick,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_start,
    input  logic              i_modify,
    input  logic              i_clear_alarm,
    input  logic [2:0]        i_cursor,
    output logic [TIME_W-1:0] o_time,
    output logic [2:0]        o_state,
    output logic              o_running,
    output logic              o_finish,
    output logic              o_alarm
);

    state_t            r_state;
    state_t            w_state_next;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] w_time_next;
    logic [TIME_W-1:0] r_preset;
    logic [TIME_W-1:0] w_preset_next;
    logic              r_running;
    logic              r_finish;
    logic              r_alarm;
    logic              w_finish_next;
    logic              w_alarm_next;
    logic              w_ack;
    logic [3:0]        w_lim;
    logic [3:0]        w_digit;
    logic [3:0]        w_digit_new;
    logic [TIME_W-1:0] w_time_edit;

    // Digit editor: step only the digit under the cursor, wrapping inside its own range.
    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (i_cursor == 3'(k)) w_digit = r_time[(N_DIGITS-1-k)*4 +: 4];
        end
        w_lim       = digit_limit(i_cursor);
        w_digit_new = w_digit;
        if (i_up && !i_down) begin
            w_digit_new = (w_digit >= w_lim) ? 4'd0 : w_digit + 4'd1;
        end else if (i_down && !i_up) begin
            w_digit_new = (w_digit == 4'd0) ? w_lim : w_digit - 4'd1;
        end
        w_time_edit = r_time;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (i_cursor == 3'(k)) w_time_edit[(N_DIGITS-1-k)*4 +: 4] = w_digit_new;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_time_next   = r_time;
        w_preset_next = r_preset;
        w_finish_next = 1'b0;
        w_ack         = 1'b0;
        case (r_state)
            ST_IDLE, ST_PAUSE: begin
                if (i_sel && i_start && (r_time != '0)) begin
                    w_state_next = ST_RUN;
                    if (r_state == ST_IDLE) w_preset_next = r_time;
                end else if (i_sel && i_modify) begin
                    w_state_next = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (!i_modify) begin
                    w_state_next = ST_IDLE;
                end else if (i_sel) begin
                    w_time_next = w_time_edit;
                end
            end
            ST_RUN: begin
                // A pause request takes priority over a tick landing in the same cycle.
                if (i_sel && i_start) begin
                    w_state_next = ST_PAUSE;
                end else if (i_tick) begin
                    if (r_time == ONE_SEC) begin
                        w_finish_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        w_time_next   = r_preset;
`else
                        w_time_next   = '0;
                        w_state_next  = ST_DONE;
`endif
                    end else begin
                        w_time_next = bcd_dec(r_time);
                    end
                end
            end
            ST_DONE: begin
                if (i_sel && i_start) begin
                    w_time_next  = r_preset;
                    w_state_next = ST_IDLE;
                    w_ack        = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Expiry in the same cycle as a clear still leaves the alarm set.
        w_alarm_next = w_finish_next | (r_alarm & ~(i_sel & i_clear_alarm) & ~w_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_time    <= '0;
            r_preset  <= '0;
            r_running <= 1'b0;
            r_finish  <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_time    <= w_time_next;
            r_preset  <= w_preset_next;
            r_running <= (w_state_next == ST_RUN);
            r_finish  <= w_finish_next;
            r_alarm   <= w_alarm_next;
        end
    end

    assign o_time    = r_time;
    assign o_state   = r_state;
    assign o_running = r_running;
    assign o_finish  = r_finish;
    assign o_alarm   = r_alarm;

endmodule

// File: rtl/countdown_multi.sv
// N_CH independent BCD countdowns sharing one tick divider, with a shared cursor and output mux.
// Optional: COUNTDOWN_AUTO_RELOAD_EN turns every channel into a periodic timer.
module countdown_multi
    import countdown_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 100000000,
    parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    input  logic              start,
    input  logic              modify,
    input  logic              clear_alarm,
    output logic [TIME_W-1:0] time_out,
    output logic [2:0]        cursor,
    output logic [2:0]        state,
    output logic [N_CH-1:0]   running,
    output logic [N_CH-1:0]   finish,
    output logic [N_CH-1:0]   alarm
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]  r_div;
    logic              w_tick;
    logic [2:0]        r_cursor;
    logic [CH_W-1:0]   r_ch_sel;
    logic [N_CH-1:0]   w_sel;
    logic [TIME_W-1:0] w_time  [N_CH];
    logic [2:0]        w_state [N_CH];

    // Free-running divider; start never re-phases it.
    assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cursor <= CUR_H1;
            r_ch_sel <= '0;
        end else begin
            r_ch_sel <= ch_sel;
            if (ch_sel != r_ch_sel) begin
                r_cursor <= CUR_H1;
            end else if (left && !right) begin
                r_cursor <= (r_cursor == CUR_H1) ? CUR_S0 : r_cursor - 3'd1;
            end else if (right && !left) begin
                r_cursor <= (r_cursor == CUR_S0) ? CUR_H1 : r_cursor + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_sel[gi] = (ch_sel == CH_W'(gi));

            countdown_channel u_channel (
                .clk           (clk),
                .rst           (rst),
                .i_sel         (w_sel[gi]),
                .i_tick        (w_tick),
                .i_up          (up),
                .i_down        (down),
                .i_start       (start),
                .i_modify      (modify),
                .i_clear_alarm (clear_alarm),
                .i_cursor      (r_cursor),
                .o_time        (w_time[gi]),
                .o_state       (w_state[gi]),
                .o_running     (running[gi]),
                .o_finish      (finish[gi]),
                .o_alarm       (alarm[gi])
            );
        end
    endgenerate

    // An out-of-range select shows a blank channel.
    always_comb begin
        time_out = '0;
        state    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_sel[i]) begin
                time_out = w_time[i];
                state    = w_state[i];
            end
        end
    end

    assign cursor = r_cursor;

endmodule

// File: tb/tb_countdown_multi.sv
// Bench for countdown_multi (N_CH=2, TICK_DIV=4): table vectors, directed corner sequences, random vs seconds-based model.
module tb_countdown_multi;

    localparam int N_CH     = 2;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst, ch_sel, up, down, left, right, start, modify, clear_alarm;
    logic [23:0] time_out;
    logic [2:0]  cursor, state;
    logic [1:0]  running, finish, alarm;

    always #5 clk = ~clk;

    countdown_multi #(.N_CH(N_CH), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst), .ch_sel(ch_sel), .up(up), .down(down), .left(left),
        .right(right), .start(start), .modify(modify), .clear_alarm(clear_alarm),
        .time_out(time_out), .cursor(cursor), .state(state),
        .running(running), .finish(finish), .alarm(alarm)
    );

    // Reference model: time held as plain seconds; states 0=IDLE 1=EDIT 2=RUN 3=PAUSE 4=DONE.
    int m_div, m_cursor, m_prev_sel;
    int m_secs[N_CH], m_preset[N_CH], m_st[N_CH];
    bit m_fin[N_CH], m_alarm[N_CH];
    int n_pass = 0, n_tot = 0;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600; m = (s / 60) % 60; x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int digit_of(input int s, input int pos);
        logic [23:0] b;
        b = to_bcd(s);
        return int'(b[(5 - pos) * 4 +: 4]);
    endfunction

    function automatic int edit_secs(input int s, input int pos, input bit inc);
        int d[6];
        int lim[6];
        lim = '{9, 9, 5, 9, 5, 9};
        for (int k = 0; k < 6; k++) d[k] = digit_of(s, k);
        if (inc) d[pos] = (d[pos] == lim[pos]) ? 0 : d[pos] + 1;
        else     d[pos] = (d[pos] == 0) ? lim[pos] : d[pos] - 1;
        return (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
    endfunction

    task automatic model_step();
        bit tick, sel, ack;
        if (rst) begin
            m_div = 0; m_cursor = 0; m_prev_sel = 0;
            for (int c = 0; c < N_CH; c++) begin
                m_secs[c] = 0; m_preset[c] = 0; m_st[c] = 0; m_fin[c] = 0; m_alarm[c] = 0;
            end
            return;
        end
        tick  = (m_div == TICK_DIV - 1);
        m_div = (m_div + 1) % TICK_DIV;
        for (int c = 0; c < N_CH; c++) begin
            sel = (int'(ch_sel) == c);
            ack = 0;
            m_fin[c] = 0;
            case (m_st[c])
                0, 3: begin
                    if (sel && start && m_secs[c] != 0) begin
                        if (m_st[c] == 0) m_preset[c] = m_secs[c];
                        m_st[c] = 2;
                    end else if (sel && modify) m_st[c] = 1;
                end
                1: begin
                    if (!modify) m_st[c] = 0;
                    else if (sel && (up != down)) m_secs[c] = edit_secs(m_secs[c], m_cursor, up);
                end
                2: begin
                    if (sel && start) m_st[c] = 3;
                    else if (tick) begin
                        if (m_secs[c] == 1) begin
                            m_fin[c] = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            m_secs[c] = m_preset[c];
`else
                            m_secs[c] = 0;
                            m_st[c]   = 4;
`endif
                        end else m_secs[c] = m_secs[c] - 1;
                    end
                end
                default: begin
                    if (sel && start) begin
                        m_secs[c] = m_preset[c]; m_st[c] = 0; ack = 1;
                    end
                end
            endcase
            m_alarm[c] = m_fin[c] || (m_alarm[c] && !(sel && clear_alarm) && !ack);
        end
        if (int'(ch_sel) != m_prev_sel) m_cursor = 0;
        else if (left && !right) m_cursor = (m_cursor + 5) % 6;
        else if (right && !left) m_cursor = (m_cursor + 1) % 6;
        m_prev_sel = int'(ch_sel);
    endtask

    function automatic logic [35:0] model_vec();
        return {to_bcd(m_secs[ch_sel]), 3'(m_cursor), 3'(m_st[ch_sel]),
                m_st[1] == 2, m_st[0] == 2, m_fin[1], m_fin[0], m_alarm[1], m_alarm[0]};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {time_out, cursor, state, running, finish, alarm};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: model consumes current inputs, DUT is sampled 1 time unit after the edge.
    task automatic tick_cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle", 64'(dut_vec()), 64'(model_vec()));
        {up, down, left, right, start, clear_alarm} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; modify = 1'b0;
        tick_cycle();
        rst = 1'b0;
    endtask

    task automatic set_digit(input int ch, input int pos, input int val);
        ch_sel = 1'(ch); modify = 1'b1;
        tick_cycle();
        for (int k = 0; k < 6 && m_cursor != pos; k++) begin right = 1'b1; tick_cycle(); end
        for (int k = 0; k < 10 && digit_of(m_secs[ch], pos) != val; k++) begin up = 1'b1; tick_cycle(); end
    endtask

    task automatic end_edit();
        modify = 1'b0;
        tick_cycle();
    endtask

    typedef struct {
        logic        sel, u, d, l, r, st, md;
        logic [23:0] e_time;
        logic [2:0]  e_cur, e_state;
    } vec_t;

    vec_t vecs[14];
    int   lat;
    int   snap;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,0,0,0,0,0,1, 24'h000000, 3'd0, 3'd1};
        vecs[1]  = '{0,0,0,1,0,0,1, 24'h000000, 3'd5, 3'd1};
        vecs[2]  = '{0,1,0,0,0,0,1, 24'h000001, 3'd5, 3'd1};
        vecs[3]  = '{0,1,1,0,0,0,1, 24'h000001, 3'd5, 3'd1};
        vecs[4]  = '{0,0,0,0,1,0,1, 24'h000001, 3'd0, 3'd1};
        vecs[5]  = '{0,0,0,0,1,0,1, 24'h000001, 3'd1, 3'd1};
        vecs[6]  = '{0,0,0,0,1,0,1, 24'h000001, 3'd2, 3'd1};
        vecs[7]  = '{0,0,1,0,0,0,1, 24'h005001, 3'd2, 3'd1};
        vecs[8]  = '{0,1,0,0,0,0,1, 24'h000001, 3'd2, 3'd1};
        vecs[9]  = '{0,0,0,1,1,0,1, 24'h000001, 3'd2, 3'd1};
        vecs[10] = '{0,0,1,0,0,0,1, 24'h005001, 3'd2, 3'd1};
        vecs[11] = '{0,0,0,0,0,0,0, 24'h005001, 3'd2, 3'd0};
        vecs[12] = '{1,0,0,0,0,0,0, 24'h000000, 3'd0, 3'd0};
        vecs[13] = '{0,0,0,0,0,0,0, 24'h005001, 3'd0, 3'd0};

        {up, down, left, right, start, clear_alarm} = '0;
        ch_sel = 1'b0; modify = 1'b0; rst = 1'b1;
        tick_cycle();
        tick_cycle();
        chk("rst_time", 64'(time_out), 64'h0);
        chk("rst_state", 64'(state), 64'h0);
        chk("rst_flags", 64'({cursor, running, finish, alarm}), 64'h0);
        rst = 1'b0;

        // Edit table on ch0: wraps, simultaneous pulses, select change.
        for (int i = 0; i < 14; i++) begin
            ch_sel = vecs[i].sel; up = vecs[i].u; down = vecs[i].d; left = vecs[i].l;
            right = vecs[i].r; start = vecs[i].st; modify = vecs[i].md;
            tick_cycle();
            chk($sformatf("vec%0d", i), 64'({time_out, cursor, state}),
                64'({vecs[i].e_time, vecs[i].e_cur, vecs[i].e_state}));
        end

        // Expiry of a 3 s count.
        do_reset();
        set_digit(0, 5, 3);
        end_edit();
        start = 1'b1;
        tick_cycle();
        chk("a_run", 64'({state, running}), 64'({3'd2, 2'b01}));
        lat = 41;
        for (int k = 1; k <= 40; k++) begin
            tick_cycle();
            if (finish[0]) begin lat = k; break; end
        end
        chk("a_latency_ok", 64'(lat >= 9 && lat <= 12), 64'h1);
        chk("a_alarm", 64'(alarm), 64'h1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk("a_reload_time", 64'(time_out), 64'h000003);
        chk("a_reload_run", 64'({state, running}), 64'({3'd2, 2'b01}));
        tick_cycle();
        chk("a_fin_pulse", 64'(finish), 64'h0);
        start = 1'b1;
        tick_cycle();
        chk("a_pause", 64'({state, running}), 64'({3'd3, 2'b00}));
`else
        chk("a_zero", 64'(time_out), 64'h000000);
        chk("a_done", 64'({state, running}), 64'({3'd4, 2'b00}));
        tick_cycle();
        chk("a_fin_pulse", 64'(finish), 64'h0);
        start = 1'b1;
        tick_cycle();
        chk("a_ack_time", 64'(time_out), 64'h000003);
        chk("a_ack_state", 64'({state, alarm}), 64'({3'd0, 2'b00}));
`endif

        // Borrow across minutes: 00:01:00 -> 00:00:59.
        do_reset();
        set_digit(0, 3, 1);
        end_edit();
        start = 1'b1;
        tick_cycle();
        for (int k = 0; k < 8 && time_out == 24'h000100; k++) tick_cycle();
        chk("b_borrow", 64'(time_out), 64'h000059);

        // Pause ch0 for 10 ticks while ch1 keeps counting, then resume.
        do_reset();
        set_digit(1, 3, 1);
        end_edit();
        set_digit(0, 3, 1);
        end_edit();
        ch_sel = 1'b1; start = 1'b1; tick_cycle();
        ch_sel = 1'b0; tick_cycle();
        start = 1'b1; tick_cycle();
        for (int k = 0; k < 6; k++) tick_cycle();
        start = 1'b1; tick_cycle();
        snap = m_secs[0];
        for (int k = 0; k < 40; k++) tick_cycle();
        chk("c_frozen", 64'(time_out), 64'(to_bcd(snap)));
        chk("c_paused", 64'({state, running}), 64'({3'd3, 2'b10}));
        ch_sel = 1'b1; tick_cycle();
        chk("c_ch1_dec", 64'(time_out < 24'h000050), 64'h1);
        ch_sel = 1'b0; tick_cycle();
        start = 1'b1; tick_cycle();
        chk("c_resume", 64'({state, running}), 64'({3'd2, 2'b11}));
        for (int k = 0; k < 5; k++) tick_cycle();

        // Reset while both channels run.
        rst = 1'b1;
        tick_cycle();
        chk("d_rst_time", 64'(time_out), 64'h0);
        chk("d_rst_flags", 64'({state, running, finish, alarm}), 64'h0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) ch_sel = ~ch_sel;
            if ($urandom_range(0, 29) == 0) modify = ~modify;
            up          = ($urandom_range(0, 7) == 0);
            down        = ($urandom_range(0, 9) == 0);
            left        = ($urandom_range(0, 9) == 0);
            right       = ($urandom_range(0, 9) == 0);
            start       = ($urandom_range(0, 11) == 0);
            clear_alarm = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 699) == 0);
            tick_cycle();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
